uart_tx_arbiter: RTL

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_pkg.sv | 34 +++
 rtl/sync_bit.sv | 26 ++
 rtl/uart_tx_arbiter.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Purpose: shared types and constants for the uart transmit path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_pkg;

  // Arbiter frame sequencing states.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_START = 3'd2,
    ST_BUSY  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Line parity selection understood by uart_tx.
  typedef enum logic [1:0] {
    PARITY_NONE = 2'd0,
    PARITY_EVEN = 2'd1,
    PARITY_ODD  = 2'd2
  } parity_t;

  // Baud rate selection understood by uart_tx.
  typedef enum logic [2:0] {
    BAUD_9600   = 3'd0,
    BAUD_19200  = 3'd1,
    BAUD_38400  = 3'd2,
    BAUD_57600  = 3'd3,
    BAUD_115200 = 3'd4
  } baud_t;

  // Default start timeout in clk cycles.
  localparam int DEFAULT_TIMEOUT = 100000;

endpackage

// File: rtl/sync_bit.sv
// Purpose: multi-flop synchronizer bringing one asynchronous bit into clk.
// Latency: STAGES clk cycles from d to q.
// Backpressure: none; samples every cycle.
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] r_sync;

  // Shift the async input through the flop chain; oldest stage drives q.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync <= '0;
    end else begin
      r_sync <= (r_sync << 1) | STAGES'(d);
    end
  end

  assign q = r_sync[STAGES-1];

endmodule

// File: rtl/uart_tx_arbiter.sv
// Purpose: round-robin sharing of one uart_tx among N_REQ byte requesters.
// Latency: ack one cycle after a request is seen in IDLE; enable the cycle after.
// Backpressure: req is held until ack; one frame in flight, others wait in IDLE.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int TIMEOUT     = DEFAULT_TIMEOUT,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req,
  input  logic [8*N_REQ-1:0]       din,
  output logic [N_REQ-1:0]         ack,
  output logic [N_REQ-1:0]         done,
  output logic                     err,
  output logic [7:0]               data_TX,
  output logic                     enable,
  input  logic                     sending,
  output logic                     busy,
  output logic [$clog2(N_REQ)-1:0] grant_id
);

  localparam int GW = $clog2(N_REQ);
  localparam int CW = $clog2(TIMEOUT + 1);

  state_t          r_state;
  state_t          w_next;
  logic [GW-1:0]   r_grant;
  logic [GW-1:0]   r_last;
  logic [GW-1:0]   w_pick;
  logic [7:0]      r_data;
  logic [CW-1:0]   r_cnt;
  logic            r_low_seen;
  logic            r_err;
  logic            w_sync;
  logic            w_rise_ok;
  logic            w_timeout;
  logic [N_REQ-1:0] w_onehot;

  // First set request searching upward from last+1, wrapping.
  function automatic logic [GW-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                            input logic [GW-1:0]    last);
    logic [GW-1:0] pick;
    logic          found;
    int            idx;
    pick  = last;
    found = 1'b0;
    for (int i = 1; i <= N_REQ; i++) begin
      idx = (int'(last) + i) % N_REQ;
      if (!found && r[idx[GW-1:0]]) begin
        pick  = idx[GW-1:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  sync_bit #(
    .STAGES(SYNC_STAGES)
  ) u_sync_sending (
    .clk  (clk),
    .reset(reset),
    .d    (sending),
    .q    (w_sync)
  );

  assign w_pick    = rr_pick(req, r_last);
  assign w_onehot  = {{(N_REQ-1){1'b0}}, 1'b1} << r_grant;
  // A rise only counts once the line has been seen idle during this START,
  // so a busy line left over from a previous frame is not mistaken for ours.
  assign w_rise_ok = w_sync && r_low_seen;
  assign w_timeout = (r_cnt == CW'(TIMEOUT - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode and state-derived outputs.
  always_comb begin
    w_next   = r_state;
    enable   = 1'b0;
    busy     = 1'b1;
    ack      = '0;
    done     = '0;
    case (r_state)
      ST_IDLE: begin
        busy = 1'b0;
        if (|req) w_next = ST_LOAD;
      end
      ST_LOAD: begin
        ack    = w_onehot;
        w_next = ST_START;
      end
      ST_START: begin
        enable = 1'b1;
        if (w_rise_ok)      w_next = ST_BUSY;
        else if (w_timeout) w_next = ST_IDLE;
      end
      ST_BUSY: begin
        if (!w_sync) w_next = ST_DONE;
      end
      ST_DONE: begin
        done   = w_onehot;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Capture the winner and its byte on the IDLE->LOAD edge so both are
  // already valid during the LOAD cycle and frozen until the next grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_grant <= '0;
      r_last  <= GW'(N_REQ - 1);
      r_data  <= '0;
    end else if (r_state == ST_IDLE && (|req)) begin
      r_grant <= w_pick;
      r_last  <= w_pick;
      r_data  <= din[{w_pick, 3'b000} +: 8];
    end
  end

  // Start timeout counter: zero outside START, saturating inside it.
  always_ff @(posedge clk) begin
    if (reset || r_state != ST_START) begin
      r_cnt <= '0;
    end else if (r_cnt != '1) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Remember whether the line has been idle since START entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_low_seen <= 1'b0;
    end else begin
      r_low_seen <= (r_state == ST_START) && (r_low_seen || !w_sync);
    end
  end

  // One-cycle err pulse, coincident with the return to IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_err <= 1'b0;
    end else begin
      r_err <= (r_state == ST_START) && !w_rise_ok && w_timeout;
    end
  end

  assign err      = r_err;
  assign data_TX  = r_data;
  assign grant_id = r_grant;

endmodule
